// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder datapath: state encoding and default width.
package serial_adder_pkg;

  localparam int SA_WIDTH = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_COLLECT = ST_COLLECT,
    S_HOLD    = ST_HOLD
  } state_e;

endpackage

// File: rtl/serial_shift_capture.sv
// LSB-first shift register plus bit-position counter for the serial sum collector.
// clr has priority over shift_en; the counter returns to zero after the last bit.
module serial_shift_capture #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             sum_bit,
  output logic [WIDTH-1:0] shreg,
  output logic [CW-1:0]    count,
  output logic             last_bit
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;

  assign shreg    = shreg_q;
  assign count    = count_q;
  assign last_bit = (count_q == CW'(WIDTH-1));

  // Next shift/count: clear on a new collection, shift one bit per qualified cycle.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (clr) begin
      shreg_d = '0;
      count_d = '0;
    end else if (shift_en) begin
      shreg_d = {sum_bit, shreg_q[WIDTH-1:1]};
      count_d = last_bit ? '0 : count_q + CW'(1);
    end
  end

  // Register the datapath; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_sum_collector.sv
// Collects the LSB-first serial sum and final carry into a parallel result
// offered on a valid/ready handshake. Optional signed-overflow output is
// enabled by defining SERIAL_COLLECT_SIGNED_OVF_EN.
module serial_sum_collector
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             sum_bit,
  input  logic             carry_bit,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready,
`ifdef SERIAL_COLLECT_SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             rv_q, rv_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic             last_bit;
  logic             shift_en;
  logic             unused_bits;

  // A bit is taken only while collecting, and never on a restart edge.
  assign shift_en    = (state_q == S_COLLECT) && bit_valid && !start;
  assign unused_bits = ^{shreg[0], count};

  serial_shift_capture #(.WIDTH(WIDTH), .CW(CW)) u_cap (
    .clk      (clk),
    .rst      (rst),
    .clr      (start),
    .shift_en (shift_en),
    .sum_bit  (sum_bit),
    .shreg    (shreg),
    .count    (count),
    .last_bit (last_bit)
  );

  // FSM and output next-state: start restarts from any state, dropping any held result.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rv_d     = rv_q;
    result_d = result_q;
    cout_d   = cout_q;
    if (start) begin
      state_d = S_COLLECT;
      busy_d  = 1'b1;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        S_COLLECT: begin
          if (bit_valid && last_bit) begin
            result_d = {sum_bit, shreg[WIDTH-1:1]};
            cout_d   = carry_bit;
            state_d  = S_HOLD;
            busy_d   = 1'b0;
            rv_d     = 1'b1;
          end
        end
        S_HOLD: begin
          if (result_ready) begin
            state_d = S_IDLE;
            rv_d    = 1'b0;
          end
        end
        S_IDLE:  ;
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          rv_d    = 1'b0;
        end
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      rv_q     <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rv_q     <= rv_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign busy         = busy_q;
  assign result_valid = rv_q;
  assign result       = result_q;
  assign cout         = cout_q;

`ifdef SERIAL_COLLECT_SIGNED_OVF_EN
  logic cim_q, cim_d;
  logic ovf_q, ovf_d;

  // Carry into the MSB is the carry out of position WIDTH-2; overflow is its XOR with carry-out.
  always_comb begin
    cim_d = cim_q;
    ovf_d = ovf_q;
    if (shift_en && count == CW'(WIDTH-2)) cim_d = carry_bit;
    if (shift_en && last_bit)              ovf_d = cim_q ^ carry_bit;
  end

  // Overflow flops; held alongside result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cim_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cim_q <= cim_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
